// File: rtl/imm_gen_pkg.sv
// Shared definitions for the pipelined RISC-V immediate generator: opcodes,
// format codes, the FIFO entry layout and the combinational decoder.
package imm_gen_pkg;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  // Widest supported datapath and sideband; instances use the low bits.
  localparam int MAX_XLEN  = 64;
  localparam int MAX_TAG_W = 16;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_SH  = 3'd6,
    FMT_ILL = 3'd7
  } imm_fmt_e;

  typedef struct packed {
    logic [MAX_XLEN-1:0]  imm;
    imm_fmt_e             fmt;
    logic                 illegal;
    logic [MAX_TAG_W-1:0] tag;
  } imm_entry_t;

  // Immediates are built sign-extended to 64 bits; truncating to 32 is still correct.
  function automatic imm_entry_t decode_imm(input logic [31:0] instr, input logic rv64);
    imm_entry_t e;
    logic [2:0] funct3;
    e      = '0;
    funct3 = instr[14:12];
    case (instr[6:0])
      OPC_OPIMM: begin
        if (funct3 == F3_SLL || funct3 == F3_SRX) begin
          e.fmt = FMT_SH;
          e.imm = rv64 ? {58'd0, instr[25:20]} : {59'd0, instr[24:20]};
        end else begin
          e.fmt = FMT_I;
          e.imm = {{52{instr[31]}}, instr[31:20]};
        end
      end
      OPC_LOAD, OPC_JALR: begin
        e.fmt = FMT_I;
        e.imm = {{52{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        e.fmt = FMT_S;
        e.imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        e.fmt = FMT_B;
        e.imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        e.fmt = FMT_U;
        e.imm = {{32{instr[31]}}, instr[31:12], 12'h000};
      end
      OPC_JAL: begin
        e.fmt = FMT_J;
        e.imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_OP: begin
        e.fmt = FMT_R;
        e.imm = '0;
      end
      default: begin
        e.fmt     = FMT_ILL;
        e.imm     = '0;
        e.illegal = 1'b1;
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/imm_gen_pipe_fifo.sv
// Generic synchronous FIFO with valid/ready on both sides and an occupancy count.
// The head is read combinationally from the storage array and zeroed while empty.
module imm_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push;
  logic             pop;

  // Full blocks the producer even if the consumer pops in the same cycle.
  assign in_ready  = (count_reg != CNT_W'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_reg;
  assign out_data  = out_valid ? mem[rd_ptr_reg] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: combinational decode of the incoming
// instruction, buffered in a small output FIFO behind a valid/ready handshake.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [31:0]            instr_i,
  input  logic [TAG_W-1:0]       tag_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [XLEN-1:0]        imm_o,
  output logic [2:0]             fmt_o,
  output logic                   illegal_o,
  output logic [TAG_W-1:0]       tag_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int ENTRY_W = XLEN + 3 + 1 + TAG_W;

  imm_entry_t       dec;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] pop_data;
  logic               unused_bits;

  always_comb begin
    dec     = decode_imm(instr_i, (XLEN == 64));
    dec.tag = MAX_TAG_W'(tag_i);
  end

  // Only the instance's XLEN/TAG_W slice of the entry is stored.
  assign push_data   = {dec.imm[XLEN-1:0], dec.fmt, dec.illegal, dec.tag[TAG_W-1:0]};
  assign unused_bits = ^{dec.imm, dec.tag};

  imm_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .in_valid  (valid_i),
    .in_ready  (ready_o),
    .in_data   (push_data),
    .out_valid (valid_o),
    .out_ready (ready_i),
    .out_data  (pop_data),
    .count     (count_o)
  );

  assign {imm_o, fmt_o, illegal_o, tag_o} = pop_data;

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator for the RV32I/RV64I datapath, sitting between instruction fetch/decode and the ID/EX register. Decodes all five RISC-V immediate formats (I, S, B, U, J) plus shift-amount immediates to an XLEN-wide value. Buffers results in a small output FIFO behind a valid/ready handshake, so decode can run ahead of a stalled execute stage. Flags opcodes it does not recognise.

## Interface
- XLEN, 32, datapath width; 32 or 64 only.
- DEPTH, 2, output FIFO entries; power of two, ≥2.
- TAG_W, 5, width of the sideband tag carried with each instruction.

- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  instr_i/tag_i valid.
- ready_o  out  1  block can accept this cycle.
- instr_i  in  32  raw instruction word.
- tag_i  in  TAG_W  opaque sideband (e.g. rd index), passed through unchanged.
- valid_o  out  1  head FIFO entry valid.
- ready_i  in  1  consumer takes head this cycle.
- imm_o  out  XLEN  decoded immediate.
- fmt_o  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, SH=6, ILL=7.
- illegal_o  out  1  opcode not recognised.
- tag_o  out  TAG_W  tag of head entry.
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Accept when valid_i && ready_o; decode is combinational on instr_i, and the result {imm, fmt, illegal, tag} is written into the FIFO tail on that edge.
- Opcode map (instr_i[6:0]), sx = sign-extend to XLEN from instr_i[31]:
  - 0010011 OP-IMM, funct3 001/101: SH, imm = zero-extended shamt; instr_i[24:20] when XLEN=32, instr_i[25:20] when XLEN=64. Other funct3: I.
  - 0000011 LOAD, 1100111 JALR: I, imm = sx(instr[31:20]).
  - 0100011 STORE: S, imm = sx({instr[31:25], instr[11:7]}).
  - 1100011 BRANCH: B, imm = sx({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 0110111 LUI, 0010111 AUIPC: U, imm = sx({instr[31:12], 12'b0}).
  - 1101111 JAL: J, imm = sx({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 0110011 OP: R, imm = 0.
  - Anything else: ILL, imm = 0, illegal = 1. The entry is still enqueued, not dropped.
- FIFO: write pointer, read pointer, and count. Pointers wrap modulo DEPTH.
  - Pop when valid_o && ready_i.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- ready_o = (count != DEPTH). No same-cycle pass-through when full: a push in a cycle where the FIFO is full is not accepted, even if a pop occurs.
- valid_o = (count != 0).
- imm_o, fmt_o, illegal_o, tag_o show the head entry while valid_o = 1, and are forced to 0 while valid_o = 0.
- ready_i with valid_o = 0: no effect.

## Timing
- Latency: an instruction accepted at edge N appears on valid_o after edge N (registered). Zero combinational path from instr_i to imm_o.
- Throughput: 1 instruction/cycle while the consumer holds ready_i = 1.
- ready_o depends only on registered count; no combinational path from ready_i to ready_o.
- Reset (asynchronous assert, released synchronously by the system): count = 0, pointers = 0, valid_o = 0, ready_o = 1, all data outputs = 0.
  - Reset asserted mid-stream discards all buffered entries; nothing is replayed.
  - Storage array contents need no reset.
- Outputs are held stable while valid_o = 1 && ready_i = 0.

## Structure
- Package imm_gen_pkg:
  - Opcode localparams (OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP).
  - Format enum imm_fmt_e (3 bits, values as in fmt_o).
  - Entry struct {imm, fmt, illegal, tag}.
- Sub-module imm_fifo: generic DEPTH × width synchronous FIFO with valid/ready, count, and async active-high reset.
- Top level holds the combinational decoder plus one imm_fifo instance.

## Test plan
- Reset: rst_i pulsed mid-stream with 2 entries buffered → valid_o = 0, count_o = 0, ready_o = 1, imm_o = 0 immediately (asynchronous).
- Format sweep (XLEN=32, ready_i=1):
  - addi x1,x0,-1 (0xFFF00093) → imm_o 0xFFFFFFFF, fmt I.
  - sw with offset -4 → 0xFFFFFFFC, fmt S.
  - beq with offset -8 → 0xFFFFFFF8, fmt B.
  - lui 0x12345 → 0x12345000, fmt U.
  - jal with offset +2048 → 0x00000800, fmt J.
  - each valid one cycle after accept.
- Shift and illegal:
  - slli shamt 31 → imm_o 31, fmt SH.
  - XLEN=64 srai shamt 63 → imm_o 63, fmt SH.
  - opcode 0x7F → illegal_o 1, fmt 7, imm_o 0, entry still popped normally.
- Backpressure: ready_i = 0, push 3 instructions with DEPTH=2 → count_o 2, ready_o 0, third instruction held by the producer. Then ready_i = 1 → entries emerge in order with tags preserved.
- Full with simultaneous pop: FIFO full, valid_i = 1, ready_i = 1 → pop occurs, push refused that cycle, count_o 1. Push accepted next cycle.
- Wrap-around: 10 back-to-back instructions with random ready_i toggling and DEPTH=4 → output sequence matches a scoreboard with no loss or duplication.
